// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Purpose  : Repeating three-segment pulse frame generator; timing parameters
//            are shadowed at each frame start.
// Revision : 1.0
// ============================================================================
module pulse_train_gen #(
    parameter int BIT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] n1,
    input  logic [BIT_WIDTH-1:0] n2,
    input  logic [BIT_WIDTH-1:0] B,
    input  logic [BIT_WIDTH-1:0] C,
    input  logic [BIT_WIDTH-1:0] D,
    input  logic [BIT_WIDTH-1:0] B1,
    input  logic [BIT_WIDTH-1:0] C1,
    input  logic [BIT_WIDTH-1:0] D1,
    input  logic [BIT_WIDTH-1:0] B2,
    input  logic [BIT_WIDTH-1:0] C2,
    input  logic [BIT_WIDTH-1:0] D2,
    input  logic [BIT_WIDTH-1:0] E,
    output logic                 pulse_out,
    output logic                 frame_start,
    output logic [1:0]           seg,
    output logic                 busy
);

    localparam logic [BIT_WIDTH-1:0] ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, S0_HI, S0_LO, S0_GAP, S1_HI, S1_LO, S1_GAP,
        S2_HI, S2_LO, S2_GAP, E_GAP
    } state_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] n1;
        logic [BIT_WIDTH-1:0] n2;
        logic [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH-1:0] c;
        logic [BIT_WIDTH-1:0] d;
        logic [BIT_WIDTH-1:0] b1;
        logic [BIT_WIDTH-1:0] c1;
        logic [BIT_WIDTH-1:0] d1;
        logic [BIT_WIDTH-1:0] b2;
        logic [BIT_WIDTH-1:0] c2;
        logic [BIT_WIDTH-1:0] d2;
        logic [BIT_WIDTH-1:0] e;
    } shadow_t;

    function automatic logic [BIT_WIDTH-1:0] len_of(input state_t s, input shadow_t p);
        case (s)
            S0_HI:   len_of = p.b;
            S0_LO:   len_of = p.c;
            S0_GAP:  len_of = p.d;
            S1_HI:   len_of = p.b1;
            S1_LO:   len_of = p.c1;
            S1_GAP:  len_of = p.d1;
            S2_HI:   len_of = p.b2;
            S2_LO:   len_of = p.c2;
            S2_GAP:  len_of = p.d2;
            E_GAP:   len_of = p.e;
            default: len_of = '0;
        endcase
    endfunction

    function automatic logic [1:0] seg_of(input state_t s);
        case (s)
            S0_HI, S0_LO, S0_GAP: seg_of = 2'd0;
            S1_HI, S1_LO, S1_GAP: seg_of = 2'd1;
            S2_HI, S2_LO, S2_GAP: seg_of = 2'd2;
            default:              seg_of = 2'd3;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_next;
    state_t               w_first;
    shadow_t              r_sh;
    shadow_t              w_in;
    shadow_t              w_sh_nx;
    logic [BIT_WIDTH-1:0] r_cnt;
    logic [BIT_WIDTH-1:0] r_pcnt;
    logic [BIT_WIDTH-1:0] w_len;
    logic [BIT_WIDTH-1:0] w_len_nx;
    logic [BIT_WIDTH-1:0] w_pcnt_inc;
    logic                 w_last;
    logic                 w_load;
    logic                 w_lo_end;
    logic                 w_next_hi;
    logic                 r_pulse;
    logic                 r_fs;
    logic [1:0]           r_seg;
    logic                 r_busy;

    assign w_in    = {n1, n2, B, C, D, B1, C1, D1, B2, C2, D2, E};
    // A frame with no segment-0 pulses begins directly in its gap.
    assign w_first = (n1 == '0) ? S0_GAP : S0_HI;

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_len      = len_of(r_state, r_sh);
        w_last     = (w_len == '0) || (r_cnt == w_len - ONE);
        w_pcnt_inc = r_pcnt + ONE;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_load = 1'b1;
                    w_next = w_first;
                end
            end
            S0_HI:  if (w_last) w_next = S0_LO;
            S0_LO:  if (w_last) w_next = (w_pcnt_inc == r_sh.n1) ? S0_GAP : S0_HI;
            S0_GAP: if (w_last) w_next = (r_sh.n2 == '0) ? S1_GAP : S1_HI;
            S1_HI:  if (w_last) w_next = S1_LO;
            S1_LO:  if (w_last) w_next = (w_pcnt_inc == r_sh.n2) ? S1_GAP : S1_HI;
            S1_GAP: if (w_last) w_next = S2_HI;
            S2_HI:  if (w_last) w_next = S2_LO;
            S2_LO:  if (w_last) w_next = S2_GAP;
            S2_GAP: if (w_last) w_next = E_GAP;
            E_GAP: begin
                if (w_last) begin
                    if (en) begin
                        w_load = 1'b1;
                        w_next = w_first;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        w_lo_end  = w_last && ((r_state == S0_LO) || (r_state == S1_LO));
        // Outputs are registered with the state, so look up the incoming phase length.
        w_sh_nx   = w_load ? w_in : r_sh;
        w_len_nx  = len_of(w_next, w_sh_nx);
        w_next_hi = (w_next == S0_HI) || (w_next == S1_HI) || (w_next == S2_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_pulse <= 1'b0;
            r_fs    <= 1'b0;
            r_seg   <= 2'd3;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sh    <= w_sh_nx;
            r_cnt   <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + ONE;
            if (seg_of(w_next) != seg_of(r_state)) begin
                r_pcnt <= '0;
            end else if (w_lo_end) begin
                r_pcnt <= w_pcnt_inc;
            end
            r_pulse <= w_next_hi && (w_len_nx != '0);
            r_fs    <= w_load;
            r_seg   <= seg_of(w_next);
            r_busy  <= (w_next != IDLE);
        end
    end

    assign pulse_out   = r_pulse;
    assign frame_start = r_fs;
    assign seg         = r_seg;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Purpose  : Directed frame sequences, parameter table and a randomized run
//            against a frame-list reference model for pulse_train_gen.
// Revision : 1.0
// ============================================================================
module tb_pulse_train_gen;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] n1, n2, B, C, D, B1, C1, D1, B2, C2, D2, E;
    logic         pulse_out;
    logic         frame_start;
    logic [1:0]   seg;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { int n1, n2, b, c, d, b1, c1, d1, b2, c2, d2, e; } prm_t;
    typedef struct { prm_t p; int exp_len; int exp_hi; } vec_t;
    typedef struct { logic p; logic [1:0] s; } cyc_t;

    cyc_t q[$];

    pulse_train_gen #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .n1         (n1),
        .n2         (n2),
        .B          (B),
        .C          (C),
        .D          (D),
        .B1         (B1),
        .C1         (C1),
        .D1         (D1),
        .B2         (B2),
        .C2         (C2),
        .D2         (D2),
        .E          (E),
        .pulse_out  (pulse_out),
        .frame_start(frame_start),
        .seg        (seg),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_params(input prm_t p);
        n1 = W'(p.n1); n2 = W'(p.n2);
        B  = W'(p.b);  C  = W'(p.c);  D  = W'(p.d);
        B1 = W'(p.b1); C1 = W'(p.c1); D1 = W'(p.d1);
        B2 = W'(p.b2); C2 = W'(p.c2); D2 = W'(p.d2);
        E  = W'(p.e);
    endtask

    // Observe one whole frame starting at its frame_start cycle.
    task automatic capture(input int chg_at, input logic [W-1:0] new_b, input logic new_en,
                           input int bound, output int len, output int hi, output int first_run,
                           output int hmask, output int s0, output int s1, output int s2,
                           output int s3);
        int  w;
        bit  in_first;
        w = 0;
        while (frame_start !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        check("frame_start_seen", int'(frame_start), 1);
        len = 0; hi = 0; first_run = 0; hmask = 0;
        s0 = 0; s1 = 0; s2 = 0; s3 = 0;
        in_first = 1'b1;
        do begin
            if (pulse_out) begin
                hi++;
                if (len < 32) hmask[len] = 1'b1;
            end
            if (in_first) begin
                if (pulse_out) first_run++;
                else if (first_run > 0) in_first = 1'b0;
            end
            case (seg)
                2'd0: s0++;
                2'd1: s1++;
                2'd2: s2++;
                default: s3++;
            endcase
            if (len == chg_at) begin
                B  = new_b;
                en = new_en;
            end
            len++;
            step();
        end while (frame_start == 1'b0 && busy == 1'b1 && len < bound);
    endtask

    // Reference model: a frame is the list of its phases, each max(L,1) cycles.
    task automatic push_phase(input logic [W-1:0] len, input bit hi, input logic [1:0] s);
        cyc_t c;
        int   n;
        n   = (len == '0) ? 1 : int'(len);
        c.p = hi && (len != '0);
        c.s = s;
        for (int i = 0; i < n; i++) q.push_back(c);
    endtask

    task automatic build_frame();
        for (int k = 0; k < int'(n1); k++) begin
            push_phase(B, 1'b1, 2'd0);
            push_phase(C, 1'b0, 2'd0);
        end
        push_phase(D, 1'b0, 2'd0);
        for (int k = 0; k < int'(n2); k++) begin
            push_phase(B1, 1'b1, 2'd1);
            push_phase(C1, 1'b0, 2'd1);
        end
        push_phase(D1, 1'b0, 2'd1);
        push_phase(B2, 1'b1, 2'd2);
        push_phase(C2, 1'b0, 2'd2);
        push_phase(D2, 1'b0, 2'd2);
        push_phase(E,  1'b0, 2'd3);
    endtask

    task automatic model_step(output int exp);
        cyc_t c;
        logic fs;
        fs  = 1'b0;
        exp = int'({1'b0, 1'b0, 2'd3, 1'b0});
        if (!rst_n) begin
            q.delete();
        end else begin
            if (q.size() == 0 && en) begin
                build_frame();
                fs = 1'b1;
            end
            if (q.size() != 0) begin
                c   = q.pop_front();
                exp = int'({c.p, fs, c.s, 1'b1});
            end
        end
    endtask

    localparam prm_t BASIC = '{2, 0, 3, 2, 4, 0, 0, 0, 0, 0, 0, 2};
    localparam int   IDLE_VEC = 6;   // {pulse=0, fs=0, seg=3, busy=0}

    initial begin
        vec_t tbl[6];
        prm_t zp;
        int   len, hi, fr, hm, s0, s1, s2, s3, w, exp;

        tbl[0] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 6, 0};
        tbl[1] = '{'{1, 1, 1, 0, 0, 2, 1, 0, 3, 0, 2, 0}, 14, 6};
        tbl[2] = '{'{3, 2, 0, 2, 1, 1, 0, 3, 0, 1, 1, 4}, 24, 2};
        tbl[3] = '{'{1, 0, 1023, 1, 1, 0, 0, 1, 1, 1, 1, 1}, 1030, 1024};
        tbl[4] = '{'{4, 3, 2, 3, 2, 1, 1, 1, 5, 2, 0, 3}, 40, 16};
        tbl[5] = '{'{1023, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 2052, 0};

        // Reset held with en high
        rst_n = 1'b0;
        en    = 1'b1;
        set_params(BASIC);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_idle", int'({pulse_out, frame_start, seg, busy}), IDLE_VEC);
        end
        rst_n = 1'b0;
        #0 rst_n = 1'b1;

        // Basic frame: first cycle is high, 20-cycle frame, back-to-back restart
        step();
        check("first_cycle_fs", int'(frame_start), 1);
        check("first_cycle_hi", int'(pulse_out), 1);
        capture(-1, 10'd3, 1'b1, 200, len, hi, fr, hm, s0, s1, s2, s3);
        check("basic_len", len, 20);
        check("basic_mask", hm, 32'h0000_00E7);
        check("basic_seg0", s0, 14);
        check("basic_seg1", s1, 1);
        check("basic_seg2", s2, 3);
        check("basic_seg3", s3, 2);
        check("basic_next_fs", int'(frame_start), 1);

        // Shadowing: B edited mid-frame only affects the following frame
        capture(4, 10'd7, 1'b1, 200, len, hi, fr, hm, s0, s1, s2, s3);
        check("shadow_cur_len", len, 20);
        check("shadow_cur_mask", hm, 32'h0000_00E7);
        capture(4, 10'd3, 1'b1, 200, len, hi, fr, hm, s0, s1, s2, s3);
        check("shadow_next_len", len, 28);
        check("shadow_first_run", fr, 7);
        check("shadow_next_hi", hi, 14);

        // Graceful stop: en dropped at cycle 6 lets the frame finish
        capture(6, 10'd3, 1'b0, 200, len, hi, fr, hm, s0, s1, s2, s3);
        check("stop_len", len, 20);
        check("stop_no_fs", int'(frame_start), 0);
        check("stop_busy_low", int'(busy), 0);
        step();
        check("stop_idle", int'({pulse_out, frame_start, seg, busy}), IDLE_VEC);

        // Zero handling: n1=0, all segment-2 lengths zero
        zp = '{0, 0, 5, 5, 4, 0, 0, 0, 0, 0, 0, 1};
        set_params(zp);
        en = 1'b1;
        capture(0, 10'd5, 1'b0, 200, len, hi, fr, hm, s0, s1, s2, s3);
        check("zero_len", len, 9);
        check("zero_hi", hi, 0);
        check("zero_s0_gap", s0, 4);
        check("zero_seg2", s2, 3);

        // Parameter table: one frame each, then stop
        for (int t = 0; t < 6; t++) begin
            set_params(tbl[t].p);
            en = 1'b1;
            capture(0, W'(tbl[t].p.b), 1'b0, 4000, len, hi, fr, hm, s0, s1, s2, s3);
            check($sformatf("tbl%0d_len", t), len, tbl[t].exp_len);
            check($sformatf("tbl%0d_hi", t), hi, tbl[t].exp_hi);
        end

        // Abort mid-pulse, then restart
        set_params(BASIC);
        en = 1'b1;
        w  = 0;
        while (frame_start !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        check("abort_fs", int'(frame_start), 1);
        step();
        check("abort_pre_hi", int'(pulse_out), 1);
        rst_n = 1'b0;
        step();
        check("abort_idle", int'({pulse_out, frame_start, seg, busy}), IDLE_VEC);
        rst_n = 1'b1;
        step();
        check("abort_restart", int'({pulse_out, frame_start, seg, busy}), 25);

        // Randomized run against the frame-list model
        rst_n = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i > 0) begin
                rst_n = ($urandom_range(0, 249) != 0);
                if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    n1 = W'($urandom_range(0, 3)); n2 = W'($urandom_range(0, 3));
                    B  = W'($urandom_range(0, 4)); C  = W'($urandom_range(0, 4));
                    D  = W'($urandom_range(0, 4)); B1 = W'($urandom_range(0, 4));
                    C1 = W'($urandom_range(0, 4)); D1 = W'($urandom_range(0, 4));
                    B2 = W'($urandom_range(0, 4)); C2 = W'($urandom_range(0, 4));
                    D2 = W'($urandom_range(0, 4)); E  = W'($urandom_range(0, 4));
                end
            end
            @(posedge clk);
            model_step(exp);
            #1;
            check("rand", int'({pulse_out, frame_start, seg, busy}), exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
